// File: rtl/dmem_store_buffer_if.sv
// Bus bundle for dmem_store_buffer: core request/response side plus the data memory side.
// master = core + memory environment, slave = the store buffer itself.
interface dmem_store_buffer_if;
   logic [31:0] req_addr;
   logic [31:0] req_dataW;
   logic [1:0]  req_store_sel;
   logic [2:0]  req_load_sel;
   logic        req_st;
   logic        req_ld;
   logic        flush;
   logic [31:0] dataR;
   logic        stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_dataW;
   logic [1:0]  mem_store_sel;
   logic [2:0]  mem_load_sel;
   logic        mem_wr_en;
   logic [31:0] mem_dataR;

   modport master (
      output req_addr, req_dataW, req_store_sel, req_load_sel, req_st, req_ld, flush, mem_dataR,
      input  dataR, stall, mem_addr, mem_dataW, mem_store_sel, mem_load_sel, mem_wr_en
   );

   modport slave (
      input  req_addr, req_dataW, req_store_sel, req_load_sel, req_st, req_ld, flush, mem_dataR,
      output dataR, stall, mem_addr, mem_dataW, mem_store_sel, mem_load_sel, mem_wr_en
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// FIFO store buffer between core and byte-addressed data memory; drains one store per non-load cycle.
// Optional macro STORE_BUF_FWD_EN: forward buffered bytes into loads instead of stalling loads.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic clk,
   input logic rst,
   dmem_store_buffer_if.slave bus
);
   localparam logic [1:0] STORE_SEL_B = 2'd0;
   localparam logic [1:0] STORE_SEL_H = 2'd1;
   localparam logic [1:0] STORE_SEL_W = 2'd2;
   localparam logic [2:0] LOAD_SEL_B  = 3'd0;
   localparam logic [2:0] LOAD_SEL_BU = 3'd1;
   localparam logic [2:0] LOAD_SEL_H  = 3'd2;
   localparam logic [2:0] LOAD_SEL_HU = 3'd3;
   localparam logic [2:0] LOAD_SEL_W  = 3'd4;

   logic [DEPTH-1:0] valid;
   logic [31:0]      e_addr [DEPTH];
   logic [31:0]      e_data [DEPTH];
   logic [2:0]       e_size [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [PTR_W:0]   count;

   logic       not_empty, stall_for_ld, drain, enq;
   logic [2:0] req_size;
   logic [7:0] raw [4];
   logic [31:0] load_word;

   assign not_empty = (count != '0);

`ifdef STORE_BUF_FWD_EN
   assign stall_for_ld = 1'b0;
`else
   assign stall_for_ld = bus.req_ld && not_empty;
`endif

   assign bus.stall = stall_for_ld || (bus.flush && not_empty);
   // A load that actually executes owns the memory port; everything else lets the head drain.
   assign drain     = not_empty && valid[head] && !(bus.req_ld && !stall_for_ld);
   assign enq       = bus.req_st && !bus.stall;

   always_comb begin
      case (bus.req_store_sel)
         STORE_SEL_B: req_size = 3'd1;
         STORE_SEL_H: req_size = 3'd2;
         default:     req_size = 3'd4;
      endcase
   end

   always_comb begin
      bus.mem_addr      = drain ? e_addr[head] : bus.req_addr;
      bus.mem_dataW     = e_data[head];
      bus.mem_wr_en     = drain;
      bus.mem_load_sel  = LOAD_SEL_W;
      case (e_size[head])
         3'd1:    bus.mem_store_sel = STORE_SEL_B;
         3'd2:    bus.mem_store_sel = STORE_SEL_H;
         default: bus.mem_store_sel = STORE_SEL_W;
      endcase
   end

   // Raw load bytes; with forwarding, entries are walked oldest to youngest so the youngest wins.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         raw[k] = bus.mem_dataR[8*k +: 8];
`ifdef STORE_BUF_FWD_EN
         for (int i = 0; i < DEPTH; i++) begin
            logic [PTR_W-1:0] idx;
            logic [31:0]      off;
            idx = head + PTR_W'(i);
            off = bus.req_addr + 32'(k) - e_addr[idx];
            if (((PTR_W+1)'(i) < count) && valid[idx] && (off < {29'd0, e_size[idx]}))
               raw[k] = e_data[idx][{off[1:0], 3'b000} +: 8];
         end
`endif
      end
   end

   always_comb begin
      case (bus.req_load_sel)
         LOAD_SEL_B:  load_word = {{24{raw[0][7]}}, raw[0]};
         LOAD_SEL_BU: load_word = {24'd0, raw[0]};
         LOAD_SEL_H:  load_word = {{16{raw[1][7]}}, raw[1], raw[0]};
         LOAD_SEL_HU: load_word = {16'd0, raw[1], raw[0]};
         LOAD_SEL_W:  load_word = {raw[3], raw[2], raw[1], raw[0]};
         default:     load_word = 32'd0;
      endcase
      bus.dataR = (bus.req_ld && !stall_for_ld) ? load_word : 32'd0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         // Clear before set: when full, the drained head slot is the slot being refilled.
         if (drain) begin
            valid[head] <= 1'b0;
            head        <= head + 1'b1;
         end
         if (enq) begin
            valid[tail] <= 1'b1;
            tail        <= tail + 1'b1;
         end
         count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(drain);
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         e_addr[tail] <= bus.req_addr;
         e_data[tail] <= bus.req_dataW;
         e_size[tail] <= req_size;
      end
   end
endmodule
